// File: rtl/rom_prog_loader.sv
// Framed byte-stream loader for the instruction ROM: parses sync/length/data/checksum,
// writes little-endian 32-bit words from address 0 and holds the CPU until a frame checks out.
module rom_prog_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    output logic        s_ready_o,
    output logic        en_w_rom_o,
    output logic [15:0] w_rom_addr_o,
    output logic [31:0] w_rom_data_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int              IW          = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   TIMEOUT_W   = IW'(TIMEOUT);
    localparam logic [16:0]     MAX_WORDS_W = 17'(MAX_WORDS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;

    function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [2:0]    state_r;
    logic          ready_r;
    logic          en_w_rom_r;
    logic [15:0]   addr_r;
    logic [31:0]   data_r;
    logic          hold_r;
    logic          done_r;
    logic          err_r;
    logic [7:0]    csum_r;
    logic [7:0]    len_lo_r;
    logic [15:0]   len_r;
    logic [15:0]   word_idx_r;
    logic [1:0]    byte_cnt_r;
    logic [23:0]   asm_r;
    logic [IW-1:0] idle_cnt_r;

    logic          hs_s;
    logic [15:0]   len_full_s;
    logic [7:0]    csum_nxt_s;

    // Handshake qualifier and per-byte helper values
    always_comb begin
        hs_s       = s_valid_i & ready_r;
        len_full_s = {s_data_i, len_lo_r};
        csum_nxt_s = csum_upd(csum_r, s_data_i);
    end

    // Frame parser, word assembler, ROM write port and status flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b0;
            en_w_rom_r <= 1'b0;
            addr_r     <= 16'd0;
            data_r     <= 32'd0;
            hold_r     <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            csum_r     <= 8'd0;
            len_lo_r   <= 8'd0;
            len_r      <= 16'd0;
            word_idx_r <= 16'd0;
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
            idle_cnt_r <= {IW{1'b0}};
        end else begin
            ready_r    <= 1'b1;
            en_w_rom_r <= 1'b0;
            if ((state_r != ST_IDLE) && !hs_s) begin
                // A stalled frame is abandoned; already-written words stay in the ROM
                if (idle_cnt_r >= TIMEOUT_W) begin
                    err_r      <= 1'b1;
                    state_r    <= ST_IDLE;
                    idle_cnt_r <= {IW{1'b0}};
                end else begin
                    idle_cnt_r <= idle_cnt_r + IW'(1);
                end
            end else begin
                idle_cnt_r <= {IW{1'b0}};
                if (hs_s) begin
                    case (state_r)
                        ST_IDLE: begin
                            if (s_data_i == 8'hA5) begin
                                done_r     <= 1'b0;
                                err_r      <= 1'b0;
                                hold_r     <= 1'b1;
                                csum_r     <= 8'd0;
                                word_idx_r <= 16'd0;
                                byte_cnt_r <= 2'd0;
                                state_r    <= ST_LEN_LO;
                            end
                        end
                        ST_LEN_LO: begin
                            len_lo_r <= s_data_i;
                            csum_r   <= csum_nxt_s;
                            state_r  <= ST_LEN_HI;
                        end
                        ST_LEN_HI: begin
                            csum_r <= csum_nxt_s;
                            len_r  <= len_full_s;
                            if (len_full_s == 16'd0) begin
                                state_r <= ST_CSUM;
                            end else if ({1'b0, len_full_s} > MAX_WORDS_W) begin
                                err_r   <= 1'b1;
                                state_r <= ST_IDLE;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            csum_r     <= csum_nxt_s;
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            if (byte_cnt_r == 2'd3) begin
                                en_w_rom_r <= 1'b1;
                                addr_r     <= word_idx_r;
                                data_r     <= {s_data_i, asm_r};
                                word_idx_r <= word_idx_r + 16'd1;
                                if (word_idx_r == (len_r - 16'd1)) begin
                                    state_r <= ST_CSUM;
                                end
                            end else begin
                                asm_r <= {s_data_i, asm_r[23:8]};
                            end
                        end
                        ST_CSUM: begin
                            if (s_data_i == csum_r) begin
                                done_r <= 1'b1;
                                hold_r <= 1'b0;
                            end else begin
                                err_r <= 1'b1;
                            end
                            state_r <= ST_IDLE;
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign s_ready_o    = ready_r;
    assign en_w_rom_o   = en_w_rom_r;
    assign w_rom_addr_o = addr_r;
    assign w_rom_data_o = data_r;
    assign cpu_hold_o   = hold_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_rom_prog_loader.sv
// Directed self-checking bench for rom_prog_loader with a small ROM model fed by the write port.
module tb_rom_prog_loader;

    localparam int MAXW = 64;
    localparam int TOUT = 16;

    logic        clk;
    logic        rst_i;
    logic        s_valid_i;
    logic [7:0]  s_data_i;
    logic        s_ready_o;
    logic        en_w_rom_o;
    logic [15:0] w_rom_addr_o;
    logic [31:0] w_rom_data_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        err_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int w0;
    logic        en_prev = 1'b0;
    logic        overlap = 1'b0;
    logic [31:0] rom_m   [0:127];
    logic [31:0] exp_w   [0:127];

    rom_prog_loader #(.MAX_WORDS(MAXW), .TIMEOUT(TOUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .en_w_rom_o   (en_w_rom_o),
        .w_rom_addr_o (w_rom_addr_o),
        .w_rom_data_o (w_rom_data_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model and write-strobe bookkeeping
    always @(negedge clk) begin
        en_prev <= en_w_rom_o;
        if (en_w_rom_o) begin
            rom_m[w_rom_addr_o[6:0]] <= w_rom_data_o;
            wr_cnt <= wr_cnt + 1;
            if (en_prev) overlap <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid_i = 1'b1;
        s_data_i  = b;
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rand_frame(input int n, input int max_gap);
        logic [7:0] cs;
        logic [7:0] b;
        int g;
        cs = 8'(n) ^ 8'(n >> 8);
        send_byte(8'hA5);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            exp_w[i] = $urandom;
            for (int k = 0; k < 4; k++) begin
                b  = 8'(exp_w[i] >> (8 * k));
                cs = cs ^ b;
                g  = $urandom_range(0, max_gap);
                if (g > 0) idle(g);
                send_byte(b);
            end
        end
        send_byte(cs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) rom_m[i] = 32'd0;
        s_valid_i = 1'b0;
        s_data_i  = 8'd0;
        rst_i     = 1'b1;
        #2 rst_i  = 1'b0;
        #20;
        chk("rst_ready", 32'(s_ready_o), 32'd0);
        chk("rst_en",    32'(en_w_rom_o), 32'd0);
        chk("rst_addr",  32'(w_rom_addr_o), 32'd0);
        chk("rst_data",  w_rom_data_o, 32'd0);
        chk("rst_hold",  32'(cpu_hold_o), 32'd1);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_err",   32'(err_o), 32'd0);
        @(negedge clk) rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(s_ready_o), 32'd1);

        // Two-word good frame, checksum 0x28
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("w0_en",   32'(en_w_rom_o), 32'd1);
        chk("w0_addr", 32'(w_rom_addr_o), 32'd0);
        chk("w0_data", w_rom_data_o, 32'h12345678);
        send_byte(8'hEF);
        chk("w0_en_pulse", 32'(en_w_rom_o), 32'd0);
        chk("w0_addr_hold", 32'(w_rom_addr_o), 32'd0);
        send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("w1_en",   32'(en_w_rom_o), 32'd1);
        chk("w1_addr", 32'(w_rom_addr_o), 32'd1);
        chk("w1_data", w_rom_data_o, 32'hDEADBEEF);
        chk("hold_before_csum", 32'(cpu_hold_o), 32'd1);
        send_byte(8'h28);
        chk("good_done", 32'(done_o), 32'd1);
        chk("good_hold", 32'(cpu_hold_o), 32'd0);
        chk("good_err",  32'(err_o), 32'd0);
        chk("good_en",   32'(en_w_rom_o), 32'd0);

        // Same frame, corrupted checksum
        w0 = wr_cnt;
        send_byte(8'hA5);
        chk("sync_clears_done", 32'(done_o), 32'd0);
        chk("sync_sets_hold",   32'(cpu_hold_o), 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h29);
        chk("bad_err",    32'(err_o), 32'd1);
        chk("bad_done",   32'(done_o), 32'd0);
        chk("bad_hold",   32'(cpu_hold_o), 32'd1);
        chk("bad_writes", 32'(wr_cnt - w0), 32'd2);

        // Oversized length, then a good one-word frame (checksum 0x45)
        w0 = wr_cnt;
        send_byte(8'hA5); send_byte(8'h41); send_byte(8'h00);
        chk("len_err",  32'(err_o), 32'd1);
        chk("len_hold", 32'(cpu_hold_o), 32'd1);
        idle(3);
        chk("len_no_write", 32'(wr_cnt - w0), 32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        chk("one_addr", 32'(w_rom_addr_o), 32'd0);
        chk("one_data", w_rom_data_o, 32'h11223344);
        send_byte(8'h45);
        chk("one_done", 32'(done_o), 32'd1);
        chk("one_err",  32'(err_o), 32'd0);
        chk("one_hold", 32'(cpu_hold_o), 32'd0);

        // Garbage before sync, then an empty frame
        w0 = wr_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        chk("garbage_keeps_done", 32'(done_o), 32'd1);
        send_byte(8'hA5);
        chk("empty_sync_done", 32'(done_o), 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("empty_done",   32'(done_o), 32'd1);
        chk("empty_err",    32'(err_o), 32'd0);
        chk("empty_writes", 32'(wr_cnt - w0), 32'd0);

        // Stall after LEN_LO: error appears exactly one cycle after the count reaches TIMEOUT
        send_byte(8'hA5); send_byte(8'h03);
        idle(TOUT);
        chk("tout_not_yet", 32'(err_o), 32'd0);
        idle(1);
        chk("tout_err",  32'(err_o), 32'd1);
        chk("tout_hold", 32'(cpu_hold_o), 32'd1);
        chk("tout_done", 32'(done_o), 32'd0);

        // Reset asserted just before the edge that would fire a write
        w0 = wr_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        s_valid_i = 1'b1;
        s_data_i  = 8'hDD;
        @(negedge clk) rst_i = 1'b0;
        #1;
        chk("mid_rst_en",    32'(en_w_rom_o), 32'd0);
        chk("mid_rst_hold",  32'(cpu_hold_o), 32'd1);
        chk("mid_rst_ready", 32'(s_ready_o), 32'd0);
        chk("mid_rst_err",   32'(err_o), 32'd0);
        s_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_en2",    32'(en_w_rom_o), 32'd0);
        chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd0);
        @(negedge clk) rst_i = 1'b1;
        @(posedge clk);
        #1;

        // 64 random words with random short gaps
        w0 = wr_cnt;
        send_rand_frame(64, 5);
        chk("rand_writes", 32'(wr_cnt - w0), 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("rand_rom[%0d]", i), rom_m[i], exp_w[i]);
        end
        chk("rand_done",    32'(done_o), 32'd1);
        chk("rand_err",     32'(err_o), 32'd0);
        chk("rand_hold",    32'(cpu_hold_o), 32'd0);
        chk("no_overlap",   32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
